ws_core_ctrl: RTL and testbench

Hardware sequencer that replaces procedural bench stimulus for weight-stationary (WS) convolution on `core`. Accepts a single `start` pulse and runs the full kernel loop over `len_kij` kernel positions, emitting the 35-bit `inst` word each cycle. Each kernel position runs: weight XMEM→L0, L0→PE load, activation XMEM→L0, execute, then OFIFO drain to PMEM. It sits directly in front of `core.inst` and observes `core.ofifo_valid`.

---
 rtl/ws_core_ctrl.sv | 158 +++++++++++++++
 tb/tb_ws_core_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ws_core_ctrl.sv
// Weight-stationary convolution sequencer: walks every kernel position through
// weight load, activation stream, execute and psum drain, emitting core.inst.
module ws_core_ctrl #(
    parameter int          COL     = 8,
    parameter int          LEN_NIJ = 36,
    parameter int          LEN_KIJ = 9,
    parameter int          GAP     = 10,
    parameter logic [10:0] W_BASE  = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [34:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij
);

    typedef struct packed {
        logic        mode;
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_L0,
        S_W_LOAD,
        S_W_GAP,
        S_A_L0,
        S_EXEC,
        S_E_GAP,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    // Both memories disabled and write-protected, every strobe low.
    localparam inst_t      IDLE_WORD   = inst_t'(35'h1800C0000);

    localparam logic [5:0] W_L0_END    = 6'(COL - 1);
    localparam logic [5:0] W_LOAD_END  = 6'(2 * COL);
    localparam logic [5:0] GAP_END     = 6'(GAP - 1);
    localparam logic [5:0] NIJ_END     = 6'(LEN_NIJ - 1);
    localparam logic [5:0] EXEC_END    = 6'(LEN_NIJ);
    localparam logic [3:0] KIJ_LAST    = 4'(LEN_KIJ - 1);

    state_t      state_q, state_d;
    inst_t       inst_q, inst_d;
    logic [5:0]  cnt_q;
    logic [3:0]  kij_q;
    logic        cnt_adv;
    logic [10:0] w_off;
    logic [10:0] p_off;

    assign w_off = 11'(kij_q) * 11'(COL);
    assign p_off = 11'(kij_q) * 11'(LEN_NIJ);

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        inst_d  = IDLE_WORD;
        cnt_adv = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                cnt_adv = 1'b0;
                if (start) state_d = S_W_L0;
            end
            S_W_L0: begin
                inst_d.cen_xmem = 1'b0;
                inst_d.a_xmem   = W_BASE + w_off + {5'b0, cnt_q};
                inst_d.l0_wr    = 1'b1;
                if (cnt_q == W_L0_END) state_d = S_W_LOAD;
            end
            S_W_LOAD: begin
                inst_d.l0_rd = 1'b1;
                inst_d.load  = 1'b1;
                if (cnt_q == W_LOAD_END) state_d = S_W_GAP;
            end
            S_W_GAP: begin
                if (cnt_q == GAP_END) state_d = S_A_L0;
            end
            S_A_L0: begin
                inst_d.cen_xmem = 1'b0;
                inst_d.a_xmem   = {5'b0, cnt_q};
                inst_d.l0_wr    = 1'b1;
                if (cnt_q == NIJ_END) state_d = S_EXEC;
            end
            S_EXEC: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
                if (cnt_q == EXEC_END) state_d = S_E_GAP;
            end
            S_E_GAP: begin
                if (cnt_q == GAP_END) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Only a cycle with data available advances the drain.
                cnt_adv = ofifo_valid;
                if (ofifo_valid) begin
                    inst_d.ofifo_rd = 1'b1;
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = p_off + {5'b0, cnt_q};
                    if (cnt_q == NIJ_END) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = (kij_q == KIJ_LAST) ? S_DONE : S_W_L0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            inst_q  <= IDLE_WORD;
            cnt_q   <= '0;
            kij_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;

            if (state_d != state_q) cnt_q <= '0;
            else if (cnt_adv)       cnt_q <= cnt_q + 6'd1;

            if (state_q == S_IDLE && start)                  kij_q <= '0;
            else if (state_q == S_NEXT && kij_q != KIJ_LAST) kij_q <= kij_q + 4'd1;
        end
    end

    assign inst = inst_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign kij  = kij_q;

endmodule

// File: tb/tb_ws_core_ctrl.sv
// Directed bench for ws_core_ctrl: full run timing, kij=2 instruction capture,
// drain throttling, mid-run reset and ignored start while busy.
module tb_ws_core_ctrl;

    localparam logic [34:0] IDLE_W   = 35'h1800C0000;
    localparam logic [34:0] W_L0_K0  = 35'h180060004;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    ws_core_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .kij        (kij)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < cycles; i++) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int done_cnt, done_t, busy_err, fixed_err;
        int load_cnt, load_first, load_last, tog_err;
        logic exp_rd;

        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b0;

        // Reset state
        do_reset(5);
        @(negedge clk);
        check("rst_inst", inst, IDLE_W);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_kij",  kij,  4'd0);

        // Run 1: valid tied high, stray start during A_L0 of kij=0
        ofifo_valid = 1'b1;
        start = 1'b1;
        t = 0;
        done_cnt = 0; done_t = -1; busy_err = 0; fixed_err = 0;
        load_cnt = 0; load_first = -1; load_last = -1;
        for (int i = 1; i <= 1400; i++) begin
            step();
            start = (t == 50);
            if (busy !== (t <= 1396)) busy_err++;
            if (done === 1'b1) begin done_cnt++; done_t = t; end
            if (inst[34] | inst[33] | inst[5] | inst[4] | ~inst[18]) fixed_err++;
            if (t == 1) begin
                check("r1_busy_c1", busy, 1'b1);
                check("r1_kij_c1",  kij,  4'd0);
            end
            if (t == 2) check("r1_first_word", inst, W_L0_K0);
            if (t >= 312 && t <= 319) begin
                check("k2_a_xmem",   inst[17:7], 11'h410 + 11'(t - 312));
                check("k2_xmem_l0w", {inst[19], inst[2]}, 2'b01);
            end
            if (t >= 300 && t <= 470 && inst[0] === 1'b1) begin
                load_cnt++;
                if (load_first < 0) load_first = t;
                load_last = t;
            end
            if (t >= 430 && t <= 465) begin
                check("k2_a_pmem", inst[30:20], 11'(72 + t - 430));
                check("k2_pmem_wr", {inst[6], inst[32], inst[31]}, 3'b100);
            end
            if (t == 1397) begin
                check("r1_end_inst", inst, IDLE_W);
                check("r1_end_kij",  kij,  4'd8);
            end
        end
        check("r1_done_cycle", done_t,    1396);
        check("r1_done_count", done_cnt,  1);
        check("r1_busy_err",   busy_err,  0);
        check("r1_fixed_err",  fixed_err, 0);
        check("k2_load_count", load_cnt,  17);
        check("k2_load_first", load_first, 320);
        check("k2_load_last",  load_last,  336);

        // Run 2: valid toggles, high on even cycles; kij=0 drain spans cycles 119..190
        do_reset(2);
        t = 0;
        ofifo_valid = 1'b1;
        start = 1'b1;
        tog_err = 0;
        for (int i = 1; i <= 192; i++) begin
            step();
            start = 1'b0;
            ofifo_valid = (t % 2 == 0);
            if (t >= 120 && t <= 191) begin
                exp_rd = (t >= 121) && ((t - 121) % 2 == 0);
                if (inst[6] !== exp_rd) tog_err++;
                if (exp_rd && inst[30:20] !== 11'((t - 121) / 2)) tog_err++;
                if (!exp_rd && inst !== IDLE_W) tog_err++;
            end
            if (t == 191) begin
                check("tog_last_pmem", inst[30:20], 11'd35);
                check("tog_last_rd",   inst[6], 1'b1);
                check("tog_kij_next",  kij, 4'd0);
            end
            if (t == 192) check("tog_kij1", kij, 4'd1);
        end
        check("tog_err", tog_err, 0);

        // Run 3: reset (with start held) during EXEC of kij=4, then restart
        do_reset(2);
        t = 0;
        ofifo_valid = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 702; i++) begin
            step();
            start = 1'b0;
            if (t == 700) begin
                check("mid_kij4",  kij, 4'd4);
                check("mid_exec",  {inst[1], inst[3]}, 2'b11);
                reset = 1'b1;
                start = 1'b1;
            end
            if (t == 701) begin
                check("mid_rst_inst", inst, IDLE_W);
                check("mid_rst_busy", busy, 1'b0);
                check("mid_rst_kij",  kij,  4'd0);
                check("mid_rst_done", done, 1'b0);
                reset = 1'b0;
            end
            if (t == 702) check("mid_idle_after", busy, 1'b0);
        end
        start = 1'b1;
        t = 0;
        step();
        start = 1'b0;
        check("rerun_busy", busy, 1'b1);
        check("rerun_kij",  kij,  4'd0);
        step();
        check("rerun_word", inst, W_L0_K0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
